// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak state geometry, inverse-chi FSM states and row table.
package keccak_pkg;
    localparam int ROW_SIZE  = 5;
    localparam int COL_SIZE  = 5;
    localparam int LANE_SIZE = 64;
    typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} inv_chi_state_t;
    // Index is the chi output row {a4..a0}; entry is the unique row that chi maps onto it.
    localparam logic [4:0] CHI_INV_LUT [32] = '{
        5'd0,  5'd11, 5'd22, 5'd9,  5'd13, 5'd4,  5'd18, 5'd15,
        5'd26, 5'd1,  5'd8,  5'd3,  5'd5,  5'd12, 5'd30, 5'd7,
        5'd21, 5'd20, 5'd2,  5'd23, 5'd16, 5'd17, 5'd6,  5'd19,
        5'd10, 5'd27, 5'd24, 5'd25, 5'd29, 5'd28, 5'd14, 5'd31
    };
endpackage

// File: rtl/inv_chi_step_if.sv
// inv_chi_step_if: valid/ready state-in and state-out channels of inv_chi_step.
interface inv_chi_step_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    keccak_pkg::state_t state_array_in;
    keccak_pkg::state_t state_array_out;
    modport master (output in_valid, state_array_in, out_ready, input in_ready, out_valid, state_array_out);
    modport slave (input in_valid, state_array_in, out_ready, output in_ready, out_valid, state_array_out);
endinterface

// File: rtl/inv_chi_row.sv
// inv_chi_row: combinational 5-bit chi-inverse of one row via the package table.
module inv_chi_row
    import keccak_pkg::*;
(
    input  logic [4:0] row_i,
    output logic [4:0] row_o
);
    assign row_o = CHI_INV_LUT[row_i];
endmodule

// File: rtl/inv_chi_step.sv
// inv_chi_step: inverts Keccak chi in place, PLANES_PER_CYCLE y-planes per cycle.
module inv_chi_step
    import keccak_pkg::*;
#(
    parameter int PLANES_PER_CYCLE = 1
) (
    input logic           clk,
    input logic           rst,
    inv_chi_step_if.slave chi_if
);
    localparam logic [2:0] STEP     = 3'(PLANES_PER_CYCLE);
    localparam logic [2:0] LAST_CNT = 3'(COL_SIZE - PLANES_PER_CYCLE);
    inv_chi_state_t state_q, state_d;
    logic [2:0] plane_cnt_q, plane_cnt_d;
    state_t work_q, work_d;
    logic [PLANES_PER_CYCLE-1:0][LANE_SIZE-1:0][4:0] row_out;
    for (genvar p = 0; p < PLANES_PER_CYCLE; p++) begin : g_p
        logic [2:0] y;
        assign y = plane_cnt_q + 3'(p);
        for (genvar z = 0; z < LANE_SIZE; z++) begin : g_z
            inv_chi_row u_row (
                .row_i({work_q[4][y][z], work_q[3][y][z], work_q[2][y][z], work_q[1][y][z], work_q[0][y][z]}),
                .row_o(row_out[p][z])
            );
        end
    end
    always_comb begin
        state_d     = state_q;
        plane_cnt_d = plane_cnt_q;
        work_d      = work_q;
        if (state_q == IDLE && chi_if.in_valid) begin
            state_d     = BUSY;
            plane_cnt_d = '0;
            work_d      = chi_if.state_array_in;
        end else if (state_q == BUSY) begin
            for (int p = 0; p < PLANES_PER_CYCLE; p++)
                for (int z = 0; z < LANE_SIZE; z++)
                    for (int x = 0; x < ROW_SIZE; x++)
                        work_d[x][plane_cnt_q + 3'(p)][z] = row_out[p][z][x];
            // Counter parks on its last value so it never passes plane 4.
            state_d     = plane_cnt_q == LAST_CNT ? DONE : BUSY;
            plane_cnt_d = plane_cnt_q == LAST_CNT ? plane_cnt_q : plane_cnt_q + STEP;
        end else if (state_q == DONE && chi_if.out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            plane_cnt_q <= '0;
            work_q      <= '0;
        end else begin
            state_q     <= state_d;
            plane_cnt_q <= plane_cnt_d;
            work_q      <= work_d;
        end
    end
    assign chi_if.in_ready        = state_q == IDLE;
    assign chi_if.out_valid       = state_q == DONE;
    assign chi_if.state_array_out = work_q;
endmodule

// File: tb/tb_inv_chi_step.sv
// tb_inv_chi_step: random chi round trips plus directed edge cases on 1- and 5-plane builds.
module tb_inv_chi_step;
    import keccak_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    state_t state_in = '0;
    int n_tests = 0;
    int n_fail = 0;
    inv_chi_step_if bus1();
    inv_chi_step_if bus5();
    assign bus1.in_valid = in_valid;
    assign bus5.in_valid = in_valid;
    assign bus1.out_ready = out_ready;
    assign bus5.out_ready = out_ready;
    assign bus1.state_array_in = state_in;
    assign bus5.state_array_in = state_in;
    inv_chi_step #(.PLANES_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .chi_if(bus1));
    inv_chi_step #(.PLANES_PER_CYCLE(5)) dut5 (.clk(clk), .rst(rst), .chi_if(bus5));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input state_t got, input state_t exp);
        chk({tag, "_biterrs"}, 64'($countones(got ^ exp)), 64'd0);
    endtask

    function automatic state_t chi(input state_t a);
        state_t b;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    b[x][y][z] = a[x][y][z] ^ (~a[(x + 1) % 5][y][z] & a[(x + 2) % 5][y][z]);
        return b;
    endfunction

    function automatic state_t rand_state();
        logic [1599:0] v;
        for (int i = 0; i < 50; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic send(input state_t s);
        chk("in_ready1", 64'(bus1.in_ready), 64'd1);
        chk("in_ready5", 64'(bus5.in_ready), 64'd1);
        in_valid = 1'b1;
        state_in = s;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(output state_t o1, output state_t o5);
        int cyc = 0;
        int lat1 = -1;
        int lat5 = -1;
        o1 = '0;
        o5 = '0;
        while ((lat1 < 0 || lat5 < 0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (lat1 < 0 && bus1.out_valid) begin lat1 = cyc; o1 = bus1.state_array_out; end
            if (lat5 < 0 && bus5.out_valid) begin lat5 = cyc; o5 = bus5.state_array_out; end
        end
        chk("latency1", 64'(lat1), 64'd5);
        chk("latency5", 64'(lat5), 64'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rel_out_valid1", 64'(bus1.out_valid), 64'd0);
        chk("rel_out_valid5", 64'(bus5.out_valid), 64'd0);
        chk("rel_in_ready1", 64'(bus1.in_ready), 64'd1);
        chk("rel_in_ready5", 64'(bus5.in_ready), 64'd1);
    endtask

    task automatic run(input state_t s, output state_t o1, output state_t o5);
        send(s);
        chk("early_ov1", 64'(bus1.out_valid), 64'd0);
        chk("early_ov5", 64'(bus5.out_valid), 64'd0);
        collect(o1, o5);
        release_out();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        state_t s, orig, o1, o5, d_orig, h1, h5;
        logic [4:0] r;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_in_ready1", 64'(bus1.in_ready), 64'd1);
        chk("rst_out_valid1", 64'(bus1.out_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready1", 64'(bus1.in_ready), 64'd1);
        chk("post_rst_in_ready5", 64'(bus5.in_ready), 64'd1);
        chk_state("rst_work1", bus1.state_array_out, '0);
        chk_state("rst_work5", bus5.state_array_out, '0);

        s = '0;
        s[0][0][0] = 1'b1;
        s[3][0][0] = 1'b1;
        orig = '0;
        orig[0][0][0] = 1'b1;
        run(s, o1, o5);
        chk_state("single_row1", o1, orig);
        chk_state("single_row5", o5, orig);

        run('0, o1, o5);
        chk_state("zeros1", o1, '0);
        chk_state("zeros5", o5, '0);
        run('1, o1, o5);
        chk_state("ones1", o1, '1);
        chk_state("ones5", o5, '1);

        s = '0;
        for (int z = 0; z < 32; z++) begin
            r = 5'(z);
            for (int x = 0; x < 5; x++) s[x][2][z] = r[x];
        end
        run(s, o1, o5);
        chk_state("exhaustive_row1", chi(o1), s);
        chk_state("exhaustive_row5", chi(o5), s);

        for (int i = 0; i < 100; i++) begin
            orig = rand_state();
            run(chi(orig), o1, o5);
            chk_state("roundtrip1", o1, orig);
            chk_state("roundtrip5", o5, orig);
        end

        orig = rand_state();
        d_orig = rand_state();
        send(chi(orig));
        collect(h1, h5);
        chk_state("bp_first1", h1, orig);
        chk_state("bp_first5", h5, orig);
        in_valid = 1'b1;
        state_in = chi(d_orig);
        repeat (10) begin
            @(negedge clk);
            chk("bp_ov1", 64'(bus1.out_valid), 64'd1);
            chk("bp_ov5", 64'(bus5.out_valid), 64'd1);
            chk("bp_ir1", 64'(bus1.in_ready), 64'd0);
            chk("bp_ir5", 64'(bus5.in_ready), 64'd0);
            chk_state("bp_hold1", bus1.state_array_out, h1);
            chk_state("bp_hold5", bus5.state_array_out, h5);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_not_yet1", 64'(bus1.in_ready), 64'd1);
        chk("bp_not_yet5", 64'(bus5.in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_taken1", 64'(bus1.in_ready), 64'd0);
        chk("bp_taken5", 64'(bus5.in_ready), 64'd0);
        collect(o1, o5);
        chk_state("bp_second1", o1, d_orig);
        chk_state("bp_second5", o5, d_orig);
        release_out();

        send(chi(rand_state()));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_ov1", 64'(bus1.out_valid), 64'd0);
        chk("rst_mid_ov5", 64'(bus5.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ir1", 64'(bus1.in_ready), 64'd1);
        chk("rst_mid_ir5", 64'(bus5.in_ready), 64'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= bus1.out_valid | bus5.out_valid;
        end
        chk("rst_no_out_valid", 64'(seen), 64'd0);
        orig = rand_state();
        run(chi(orig), o1, o5);
        chk_state("after_rst1", o1, orig);
        chk_state("after_rst5", o5, orig);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inv_chi_step.md
INV_CHI_STEP -- requirements
Module: inv_chi_step

Interface
REQ-001 Parameter: PLANES_PER_CYCLE, default 1; y-planes inverted per cycle; legal values 1 or 5 only.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  state_array_in holds a state to invert.
REQ-005 in_ready  output  1  block can accept a state this cycle.
REQ-006 state_array_in  input  [ROW_SIZE][COL_SIZE][LANE_SIZE] (1600 b)  chi output, indexed [x][y][z].
REQ-007 out_valid  output  1  state_array_out holds the finished inverse.
REQ-008 out_ready  input  1  consumer accepts state_array_out this cycle.
REQ-009 state_array_out  output  [ROW_SIZE][COL_SIZE][LANE_SIZE]  chi-inverse of the accepted state, [x][y][z].

Function
REQ-010 For every y, z: the 5-bit row r = {A[4][y][z]..A[0][y][z]} maps to chi^-1(r), where chi(a)[x] = a[x] ^ (~a[(x+1)%5] & a[(x+2)%5]).
REQ-011 Row inversion is an exact 32-entry lookup, with no iterative approximation; chi(chi^-1(r)) = r for all 32 r.
REQ-012 FSM states: IDLE, BUSY, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid, capture state_array_in into the working register, clear plane_cnt to 0, and go to BUSY.
REQ-014 BUSY: in_ready=0, out_valid=0; each cycle, replace planes plane_cnt..plane_cnt+PLANES_PER_CYCLE-1 of the working register in place with their inverses, then advance plane_cnt by PLANES_PER_CYCLE.
REQ-015 BUSY to DONE: in the cycle the plane with y=4 is processed; plane_cnt never exceeds 4 and does not wrap.
REQ-016 DONE: out_valid=1, in_ready=0; state_array_out is held stable; on out_ready go to IDLE.
REQ-017 Latency: after in_valid&in_ready is sampled at edge N, out_valid=1 after edge N+5/PLANES_PER_CYCLE (N+5 or N+1).
REQ-018 Throughput: one state per 5/PLANES_PER_CYCLE + 2 cycles; no overlap of accept and deliver.
REQ-019 in_valid while BUSY/DONE is ignored; the upstream holds it until in_ready.
REQ-020 out_ready while IDLE/BUSY is ignored.
REQ-021 state_array_out drives the working register directly; its value outside DONE is don't-care to the consumer.
REQ-022 Planes not yet processed retain the captured input bits; planes are never processed twice.

Reset
REQ-023 rst asserted: FSM goes to IDLE, plane_cnt=0, working register=0, out_valid=0, and in_ready=1 once rst deasserts.
REQ-024 rst mid-BUSY or mid-DONE discards the state in flight; no out_valid pulse is produced for it.
REQ-025 First acceptance occurs no earlier than the first rising edge with rst low.

Structure
REQ-026 ROW_SIZE=5, COL_SIZE=5, and LANE_SIZE=64 come from keccak_pkg.
REQ-027 The FSM state enum type inv_chi_state_t is added to keccak_pkg.
REQ-028 The 32-entry chi-inverse constant table is added to keccak_pkg.
REQ-029 One combinational sub-module, inv_chi_row, maps 5-bit row to 5-bit inverse via the package table.
REQ-030 inv_chi_row is instantiated LANE_SIZE*PLANES_PER_CYCLE times; plane selection uses a plane_cnt mux.
REQ-031 Target size: 120-400 lines of RTL including the sub-module.

Verification
REQ-032 Single row: A[0][0][0]=1, A[3][0][0]=1, all other bits 0 -> output A[0][0][0]=1 only (chi^-1(9)=1).
REQ-033 All-zero state -> all-zero output; all-ones state -> all-ones output; out_valid after exactly 5 cycles (PLANES_PER_CYCLE=1).
REQ-034 Round trip: 100 random states passed through chi_step, then fed here -> output equals the original state bit-exact, for PLANES_PER_CYCLE=1 and 5.
REQ-035 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, output stable, in_ready=0; a second in_valid is not accepted until a cycle after out_ready.
REQ-036 rst pulsed at BUSY cycle 3 -> out_valid never rises for that state; in_ready=1 in the cycle after rst deasserts; the next state completes correctly.
REQ-037 Exhaustive row: all 32 values placed in plane y=2 across z=0..31 -> each output row r satisfies chi(r)=input row.
